apb_req_master: RTL and testbench



---
 rtl/apb_req_master_pkg.sv | 15 +
 rtl/apb_req_master_timeout.sv | 43 ++++
 rtl/apb_req_master.sv | 133 +++++++++++++
 tb/tb_apb_req_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_master_pkg.sv
// Shared types and helpers for the request-to-APB3 bridge.
package apb_req_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Bits needed to hold 0..limit; a disabled timeout still gets one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_req_master_timeout.sv
// Saturating ACCESS-cycle counter; expired_o flags the LIMIT-th stalled cycle.
module apb_timeout_cnt
  import apb_req_master_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] SAT = (LIMIT == 0) ? {W{1'b1}} : W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count lags the current ACCESS cycle by one, hence LIMIT-1.
  if (LIMIT == 0) begin : g_no_timeout
    assign expired_o = 1'b0;
  end else begin : g_timeout
    assign expired_o = (cnt_q == W'(LIMIT - 1));
  end

endmodule

// File: rtl/apb_req_master.sv
// Request/grant core port to APB3 initiator with stall timeout.
//   IDLE   | no transfer, gnt_o high, APB address/data hold last value
//   SETUP  | psel high, penable low, timeout counter cleared
//   ACCESS | psel+penable high, wait for pready or timeout abort
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      gnt;
  logic                      cnt_clr, cnt_en, cnt_expired;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt = 1'b1;
        if (req_i) state_d = SETUP;
      end
      SETUP: begin
        cnt_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready in the last allowed cycle completes normally, not as a timeout
        if (pready_i) begin
          gnt      = 1'b1;
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : prdata_i;
          err_d    = pslverr_i;
          state_d  = req_i ? SETUP : IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            err_d    = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) gnt = 1'b0;

    if (gnt && req_i) begin
      paddr_d  = addr_i;
      pwdata_d = wdata_i;
      pwrite_d = we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign gnt_o     = gnt;
  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master; responses checked by a queue-based monitor.
module tb_apb_req_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          gnt_o, rvalid_o, err_o;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pwrite_o, psel_o, penable_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i, pslverr_i;

  always #5 clk = ~clk;

  apb_req_master #(
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pwrite_o  (pwrite_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [DW-1:0] rdata, input logic err, input int at_cyc);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.cyc   = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: rvalid=1 with no response pending (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rdata_o), 64'(e.rdata));
        chk("rsp_err", 64'(err_o), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("reset_ctrl", {58'd0, psel_o, penable_o, rvalid_o, err_o, pwrite_o, gnt_o}, 64'd0);
    chk("reset_paddr", 64'(paddr_o), 64'd0);
    chk("reset_rdata", 64'(rdata_o), 64'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_gnt", 64'(gnt_o), 64'd1);

    // Zero-wait read
    step();
    c = cyc;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_0004; pready_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
    expect_rsp(32'hDEAD_BEEF, 1'b0, c + 3);
    @(negedge clk);
    chk("rd_gnt", 64'(gnt_o), 64'd1);
    step();
    req_i = 1'b0; addr_i = '0;
    @(negedge clk);
    chk("rd_setup_sel", {62'd0, psel_o, penable_o}, 64'b10);
    chk("rd_paddr", 64'(paddr_o), 64'h1A10_0004);
    chk("rd_pwrite", 64'(pwrite_o), 64'd0);
    step();
    @(negedge clk);
    chk("rd_access_sel", {62'd0, psel_o, penable_o}, 64'b11);
    drain();

    // Write, 3 wait states, slave error
    c = cyc;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1A10_0100; wdata_i = 32'h1234_5678;
    pready_i = 1'b0; pslverr_i = 1'b1; prdata_i = 32'hFFFF_FFFF;
    expect_rsp('0, 1'b1, c + 6);
    @(negedge clk);
    chk("wr_gnt", 64'(gnt_o), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      req_i = 1'b0; wdata_i = 32'h0; we_i = 1'b0;
      pready_i = (k == 5);
      @(negedge clk);
      if (k <= 5) begin
        chk("wr_pwdata", 64'(pwdata_o), 64'h1234_5678);
        chk("wr_psel", 64'(psel_o), 64'd1);
      end else begin
        chk("wr_psel_done", 64'(psel_o), 64'd0);
      end
      if (k >= 2 && k <= 5) chk("wr_penable", 64'(penable_o), 64'd1);
    end
    pready_i = 1'b0; pslverr_i = 1'b0;
    drain();

    // Back-to-back zero-wait reads
    c = cyc;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      req_i = (k <= 6); we_i = 1'b0; addr_i = 32'h100 + 32'(k * 4);
      pready_i = 1'b1; prdata_i = 32'hA000_0000 + 32'(k);
      if (k <= 6 && (k % 2 == 0)) expect_rsp(32'hA000_0000 + 32'(k + 2), 1'b0, c + k + 3);
      @(negedge clk);
      if (k <= 7) chk("b2b_gnt", 64'(gnt_o), 64'(k % 2 == 0));
      chk("b2b_penable", 64'(penable_o), 64'(k >= 2 && (k % 2 == 0)));
      chk("b2b_psel", 64'(psel_o), 64'(k >= 1 && k <= 8));
      if (k <= 7 && (k % 2 == 1)) chk("b2b_paddr", 64'(paddr_o), 64'(32'h100 + 32'((k - 1) * 4)));
    end
    req_i = 1'b0; pready_i = 1'b0;
    drain();

    // Timeout, slave never ready
    c = cyc;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_0200; pready_i = 1'b0; prdata_i = 32'h7777_7777;
    expect_rsp('0, 1'b1, c + 6);
    @(negedge clk);
    chk("to_gnt", 64'(gnt_o), 64'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      req_i = 1'b0;
      @(negedge clk);
      chk("to_psel", 64'(psel_o), 64'(k <= 5));
      chk("to_penable", 64'(penable_o), 64'(k >= 2 && k <= 5));
    end
    drain();

    // Ready in the last allowed ACCESS cycle beats the timeout
    c = cyc;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_0300; pready_i = 1'b0;
    prdata_i = 32'h5A5A_5A5A; pslverr_i = 1'b1;
    expect_rsp(32'h5A5A_5A5A, 1'b1, c + 6);
    for (int k = 1; k <= 6; k++) begin
      step();
      req_i = 1'b0;
      pready_i = (k == 5);
      @(negedge clk);
      chk("bnd_psel", 64'(psel_o), 64'(k <= 5));
    end
    pready_i = 1'b0; pslverr_i = 1'b0;
    drain();

    // Reset in ACCESS: no response, then a clean transfer
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h1A10_0400; wdata_i = 32'hCAFE_F00D; pready_i = 1'b0;
    step();
    req_i = 1'b0;
    step();
    @(negedge clk);
    chk("rst_mid_in_access", {62'd0, psel_o, penable_o}, 64'b11);
    rst_i = 1'b1; pready_i = 1'b1;
    step();
    @(negedge clk);
    chk("rst_mid_ctrl", {59'd0, psel_o, penable_o, rvalid_o, pwrite_o, gnt_o}, 64'd0);
    chk("rst_mid_paddr", 64'(paddr_o), 64'd0);
    chk("rst_mid_pwdata", 64'(pwdata_o), 64'd0);
    step();
    rst_i = 1'b0; pready_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_gnt", 64'(gnt_o), 64'd1);
    repeat (3) step();
    c = cyc;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_0500; pready_i = 1'b1; prdata_i = 32'h0BAD_CAFE;
    expect_rsp(32'h0BAD_CAFE, 1'b0, c + 3);
    step();
    req_i = 1'b0;
    @(negedge clk);
    chk("post_rst_paddr", 64'(paddr_o), 64'h1A10_0500);
    drain();
    pready_i = 1'b0;

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
